// File: rtl/idu_pkg.sv
// rtl/idu_pkg.sv - shared decode constants and buffer state encoding for the IDU
package idu_pkg;

    localparam logic [2:0] EXT_I = 3'b000;
    localparam logic [2:0] EXT_U = 3'b001;
    localparam logic [2:0] EXT_S = 3'b010;
    localparam logic [2:0] EXT_B = 3'b011;
    localparam logic [2:0] EXT_J = 3'b100;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Encoded as {skid.valid, main.valid} so the outputs fall straight out of the state bits.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } buf_state_e;

endpackage

// File: rtl/idu_opcode_predecode.sv
// rtl/idu_opcode_predecode.sv - RV32I opcode to immediate-format select and illegal flag
module idu_opcode_predecode
    import idu_pkg::*;
(
    input  logic [6:0] opcode_i,
    output logic [2:0] ext_opt_o,
    output logic       illegal_o
);

    // Every supported opcode ends in 2'b11, so a bad inst[1:0] falls into the default arm.
    always_comb begin
        ext_opt_o = EXT_I;
        illegal_o = 1'b0;
        case (opcode_i)
            OPC_LUI, OPC_AUIPC: ext_opt_o = EXT_U;
            OPC_JAL:            ext_opt_o = EXT_J;
            OPC_BRANCH:         ext_opt_o = EXT_B;
            OPC_STORE:          ext_opt_o = EXT_S;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM,
            OPC_OP, OPC_FENCE:  ext_opt_o = EXT_I;
            default:            illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/idu_inst_buffer.sv
// rtl/idu_inst_buffer.sv - two-entry IFU->IDU skid buffer with opcode predecode
// Optional performance counters are enabled by defining IDU_BUF_PERF_EN.
module idu_inst_buffer
    import idu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic [2:0]      out_ext_opt,
    output logic            out_illegal,
`ifdef IDU_BUF_PERF_EN
    output logic [31:0]     perf_issue_cnt,
    output logic [31:0]     perf_full_cnt,
    output logic [31:0]     perf_flush_cnt,
`endif
    input  logic            flush
);

    buf_state_e      state_q;
    logic [XLEN-1:0] main_inst_q, main_pc_q, skid_inst_q, skid_pc_q;
    logic [2:0]      main_ext_q, skid_ext_q;
    logic            main_ill_q, skid_ill_q;

    logic [2:0]      in_ext_d;
    logic            in_ill_d;
    logic            in_fire, out_fire;

    idu_opcode_predecode u_predecode (
        .opcode_i  (in_inst[6:0]),
        .ext_opt_o (in_ext_d),
        .illegal_o (in_ill_d)
    );

    // in_ready depends only on registered state, keeping out_ready off the input path.
    assign in_ready    = ~state_q[1];
    assign out_valid   = state_q[0];
    assign in_fire     = in_valid & in_ready;
    assign out_fire    = out_valid & out_ready;

    assign out_inst    = main_inst_q;
    assign out_pc      = main_pc_q;
    assign out_ext_opt = main_ext_q;
    assign out_illegal = main_ill_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_EMPTY;
            main_inst_q <= XLEN'(NOP_INST);
            main_pc_q   <= RESET_PC;
            main_ext_q  <= EXT_I;
            main_ill_q  <= 1'b0;
            skid_inst_q <= XLEN'(NOP_INST);
            skid_pc_q   <= RESET_PC;
            skid_ext_q  <= EXT_I;
            skid_ill_q  <= 1'b0;
        end else if (flush) begin
            state_q <= ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_inst_q <= in_inst;
                        main_pc_q   <= in_pc;
                        main_ext_q  <= in_ext_d;
                        main_ill_q  <= in_ill_d;
                        state_q     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_inst_q <= in_inst;
                        main_pc_q   <= in_pc;
                        main_ext_q  <= in_ext_d;
                        main_ill_q  <= in_ill_d;
                    end else if (in_fire) begin
                        skid_inst_q <= in_inst;
                        skid_pc_q   <= in_pc;
                        skid_ext_q  <= in_ext_d;
                        skid_ill_q  <= in_ill_d;
                        state_q     <= ST_FULL;
                    end else if (out_fire) begin
                        state_q     <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        main_inst_q <= skid_inst_q;
                        main_pc_q   <= skid_pc_q;
                        main_ext_q  <= skid_ext_q;
                        main_ill_q  <= skid_ill_q;
                        state_q     <= ST_ONE;
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

`ifdef IDU_BUF_PERF_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_issue_cnt <= 32'd0;
            perf_full_cnt  <= 32'd0;
            perf_flush_cnt <= 32'd0;
        end else begin
            if (out_fire)
                perf_issue_cnt <= perf_issue_cnt + 32'd1;
            if (state_q == ST_FULL)
                perf_full_cnt  <= perf_full_cnt + 32'd1;
            if (flush && state_q != ST_EMPTY)
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_idu_inst_buffer.sv
// tb/tb_idu_inst_buffer.sv - directed table-driven bench for idu_inst_buffer
module tb_idu_inst_buffer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready, out_valid, out_ready, out_illegal, flush;
    logic [31:0] in_inst, in_pc, out_inst, out_pc;
    logic [2:0]  out_ext_opt;
`ifdef IDU_BUF_PERF_EN
    logic [31:0] perf_issue_cnt, perf_full_cnt, perf_flush_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    idu_inst_buffer dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inst     (in_inst),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .out_ext_opt (out_ext_opt),
        .out_illegal (out_illegal),
`ifdef IDU_BUF_PERF_EN
        .perf_issue_cnt (perf_issue_cnt),
        .perf_full_cnt  (perf_full_cnt),
        .perf_flush_cnt (perf_flush_cnt),
`endif
        .flush       (flush)
    );

    typedef struct {
        logic        iv;
        logic [31:0] inst;
        logic [31:0] pc;
        logic        ordy;
        logic        fl;
        logic        e_ov;
        logic        e_ir;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        logic [2:0]  e_ext;
        logic        e_ill;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    function automatic vec_t mk(logic iv, logic [31:0] inst, logic [31:0] pc, logic ordy,
                                logic fl, logic e_ov, logic e_ir, logic [31:0] e_inst,
                                logic [31:0] e_pc, logic [2:0] e_ext, logic e_ill);
        vec_t v;
        v.iv = iv; v.inst = inst; v.pc = pc; v.ordy = ordy; v.fl = fl;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_inst = e_inst; v.e_pc = e_pc;
        v.e_ext = e_ext; v.e_ill = e_ill;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic e_ov, input logic e_ir,
                           input logic [31:0] e_inst, input logic [31:0] e_pc,
                           input logic [2:0] e_ext, input logic e_ill);
        chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, e_ov});
        chk({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, e_ir});
        if (e_ov) begin
            chk({tag, ".out_inst"},    out_inst, e_inst);
            chk({tag, ".out_pc"},      out_pc, e_pc);
            chk({tag, ".out_ext_opt"}, {29'd0, out_ext_opt}, {29'd0, e_ext});
            chk({tag, ".out_illegal"}, {31'd0, out_illegal}, {31'd0, e_ill});
        end
    endtask

    initial begin
        //             iv  inst          pc            ordy fl   ov  ir  e_inst        e_pc          ext     ill
        vecs[0]  = mk(1, 32'h0010_0093, 32'h8000_0000, 1, 0,   1, 1, 32'h0010_0093, 32'h8000_0000, 3'b000, 0);
        vecs[1]  = mk(1, 32'h1234_50B7, 32'h8000_0004, 1, 0,   1, 1, 32'h1234_50B7, 32'h8000_0004, 3'b001, 0);
        vecs[2]  = mk(1, 32'h0011_2223, 32'h8000_0008, 1, 0,   1, 1, 32'h0011_2223, 32'h8000_0008, 3'b010, 0);
        vecs[3]  = mk(1, 32'h0080_00EF, 32'h8000_000C, 1, 0,   1, 1, 32'h0080_00EF, 32'h8000_000C, 3'b100, 0);
        vecs[4]  = mk(0, 32'h0,         32'h0,         1, 0,   0, 1, 32'h0,         32'h0,         3'b000, 0);
        vecs[5]  = mk(1, 32'h0020_0113, 32'h8000_0010, 0, 0,   1, 1, 32'h0020_0113, 32'h8000_0010, 3'b000, 0);
        vecs[6]  = mk(1, 32'h0030_0193, 32'h8000_0014, 0, 0,   1, 0, 32'h0020_0113, 32'h8000_0010, 3'b000, 0);
        vecs[7]  = mk(1, 32'h0000_0003, 32'h8000_0099, 0, 0,   1, 0, 32'h0020_0113, 32'h8000_0010, 3'b000, 0);
        vecs[8]  = mk(0, 32'h0,         32'h0,         1, 0,   1, 1, 32'h0030_0193, 32'h8000_0014, 3'b000, 0);
        vecs[9]  = mk(0, 32'h0,         32'h0,         1, 0,   0, 1, 32'h0,         32'h0,         3'b000, 0);
        vecs[10] = mk(1, 32'h0040_0213, 32'h8000_0018, 0, 0,   1, 1, 32'h0040_0213, 32'h8000_0018, 3'b000, 0);
        vecs[11] = mk(1, 32'h0050_0293, 32'h8000_001C, 0, 0,   1, 0, 32'h0040_0213, 32'h8000_0018, 3'b000, 0);
        vecs[12] = mk(1, 32'h0060_0313, 32'h8000_0020, 0, 1,   0, 1, 32'h0,         32'h0,         3'b000, 0);
        vecs[13] = mk(0, 32'h0,         32'h0,         1, 0,   0, 1, 32'h0,         32'h0,         3'b000, 0);
        vecs[14] = mk(1, 32'h0000_007F, 32'h8000_0024, 1, 0,   1, 1, 32'h0000_007F, 32'h8000_0024, 3'b000, 1);
        vecs[15] = mk(1, 32'h0020_8463, 32'h8000_0028, 1, 0,   1, 1, 32'h0020_8463, 32'h8000_0028, 3'b011, 0);
        vecs[16] = mk(1, 32'h0000_0062, 32'h8000_002C, 1, 0,   1, 1, 32'h0000_0062, 32'h8000_002C, 3'b000, 1);
        vecs[17] = mk(1, 32'h0000_0097, 32'h8000_0030, 1, 0,   1, 1, 32'h0000_0097, 32'h8000_0030, 3'b001, 0);
        vecs[18] = mk(0, 32'h0,         32'h0,         1, 0,   0, 1, 32'h0,         32'h0,         3'b000, 0);

        reset_n = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk_out("reset", 1'b0, 1'b1, 32'h0, 32'h0, 3'b000, 1'b0);
        chk("reset.out_inst", out_inst, 32'h0000_0013);
        chk("reset.out_pc", out_pc, 32'h8000_0000);
        chk("reset.out_ext_opt", {29'd0, out_ext_opt}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clock);
            in_valid = vecs[i].iv; in_inst = vecs[i].inst; in_pc = vecs[i].pc;
            out_ready = vecs[i].ordy; flush = vecs[i].fl;
            @(posedge clock);
            #1;
            chk_out($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_ir, vecs[i].e_inst,
                    vecs[i].e_pc, vecs[i].e_ext, vecs[i].e_ill);
        end

        // Fill the buffer, then pull reset between edges.
        @(negedge clock);
        in_valid = 1'b1; in_inst = 32'h0070_0393; in_pc = 32'h8000_0040; out_ready = 1'b0; flush = 1'b0;
        @(negedge clock);
        in_inst = 32'h0080_0413; in_pc = 32'h8000_0044;
        @(posedge clock);
        #1;
        chk_out("prereset", 1'b1, 1'b0, 32'h0070_0393, 32'h8000_0040, 3'b000, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async.out_valid", {31'd0, out_valid}, 32'd0);
        chk("async.in_ready", {31'd0, in_ready}, 32'd1);
        chk("async.out_pc", out_pc, 32'h8000_0000);
        chk("async.out_inst", out_inst, 32'h0000_0013);
        @(negedge clock);
        reset_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clock);
        #1;
        chk_out("postreset", 1'b0, 1'b1, 32'h0, 32'h0, 3'b000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
